pipo_rr_load_ctrl: RTL and testbench
====================================

// Module: pipo_rr_load_ctrl
// PURPOSE
//   Round-robin load controller for one shared n-bit PIPO holding register.
//   Arbitrates NREQ valid/ready writers and drives the register's load/pi inputs.
//   Presents the held word downstream as a one-entry valid/ready stage, tagged with the owning requester.
//   Sits between producer blocks and the PIPO register. Its reset is tied to the register's reset.
// PARAMETERS
//   NREQ  4  number of requesters (>=1)
//   W     8  data width; equals the PIPO register's n
//   IW    (NREQ>1 ? $clog2(NREQ) : 1)  owner index width (localparam)
// PORTS
//   clk        in   1        clock, rising edge
//   reset      in   1        synchronous, active-high
//   req_valid  in   NREQ     per-requester write request
//   req_data   in   NREQ*W   requester i's word at [i*W +: W]
//   req_ready  out  NREQ     one-hot grant; transfer happens when req_valid[i]&req_ready[i]
//   reg_load   out  1        to PIPO load
//   reg_pi     out  W        to PIPO pi
//   out_valid  out  1        held word on PIPO po is valid
//   out_ready  in   1        downstream accepts held word
//   out_owner  out  IW       index of requester that wrote the held word
// BEHAVIOUR
//   Reset values: out_valid=0, out_owner=0, rr pointer=0. req_ready=0 and reg_load=0 during the reset cycle.
//   States: EMPTY (out_valid=0) and FULL (out_valid=1).
//   can_load = ~reset & (EMPTY | out_ready).
//   Grant: g = first i with req_valid[i], searching ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
//     Grant is issued only if can_load and at least one req_valid is set.
//   req_ready, reg_load and reg_pi are combinational on the grant cycle:
//     req_ready=onehot(g), reg_load=1, reg_pi=req_data[g].
//     With no grant: req_ready=0, reg_load=0, reg_pi=0.
//   Registered on the grant edge: state<=FULL, out_owner<=g, ptr<=(g==NREQ-1)?0:g+1.
//   Latency: word visible on po, with out_valid=1, one cycle after grant.
//   Pop: FULL with out_ready=1 and no grant gives state<=EMPTY.
//     FULL with out_ready=1 and a grant refills the same cycle, so throughput is one word per cycle.
//   FULL with out_ready=0: no grant; register, owner and ptr hold.
//   out_ready while EMPTY is ignored.
//   ptr advances only on a grant.
//   req_ready may depend on req_valid. Requesters must not gate req_valid on req_ready.
//   NREQ=1: ptr stays 0, owner is always 0.
//   Mid-operation reset: the held word is discarded (out_valid=0 next cycle) and ptr returns to 0.
//     No load occurs in the reset cycle.
// STRUCTURE
//   Shared package: state encoding (ST_EMPTY, ST_FULL) and the IW width function.
//   Sub-module rr_pick #(NREQ): combinational rotating priority pick (valid vector, ptr -> any, g).
//   The PIPO register is instantiated by the parent; this block holds no data storage.
// TESTING
//   1. Reset, then req_valid=4'b0100, data2=8'hA5.
//      -> req_ready=4'b0100 and reg_load=1 the same cycle; next cycle out_valid=1, owner=2, po=A5.
//   2. All 4 requesters valid, out_ready=1 held.
//      -> grants 0,1,2,3,0 on consecutive cycles; owner trails grant by one cycle.
//   3. FULL with out_ready=0 for 5 cycles and req_valid=4'b1111.
//      -> req_ready=0 and reg_load=0 throughout; po and owner stable.
//   4. FULL with out_ready=1 and req_valid=0001 (ptr=1).
//      -> grant 0 that cycle, out_valid stays 1, owner=0.
//   5. FULL with out_ready=1 and no req_valid.
//      -> out_valid=0 next cycle; a later req_valid on requester 3 gives owner=3.
//   6. Reset asserted while FULL with requests pending.
//      -> no grant in the reset cycle; next cycle out_valid=0, po=0, ptr=0, first grant goes to lowest valid index.

Source files
------------

// File: rtl/pipo_rr_load_ctrl_pkg.sv
// Shared definitions for the round-robin PIPO load controller.
package pipo_rr_load_ctrl_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Owner/pointer index width; a single requester still needs one bit.
    function automatic int iw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipo_rr_load_ctrl_rr_pick.sv
// Combinational rotating-priority pick: first valid index at or after ptr, wrapping.
module rr_pick
    import pipo_rr_load_ctrl_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         valid,
    input  logic [iw_of(NREQ)-1:0]  ptr,
    output logic                    any,
    output logic [iw_of(NREQ)-1:0]  g
);

    localparam int IW = iw_of(NREQ);

    int unsigned idx;

    // Scan offsets from farthest to nearest so the nearest valid index wins.
    always_comb begin
        any = |valid;
        g   = '0;
        idx = 0;
        for (int unsigned k = NREQ; k > 0; k--) begin
            idx = int'(ptr) + k - 1;
            if (idx >= NREQ)
                idx = idx - NREQ;
            if (valid[idx])
                g = IW'(idx);
        end
    end

endmodule

// File: rtl/pipo_rr_load_ctrl.sv
// Round-robin load controller for a shared PIPO register; presents the held word as a one-entry stage.
module pipo_rr_load_ctrl
    import pipo_rr_load_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*W-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    reg_load,
    output logic [W-1:0]            reg_pi,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [iw_of(NREQ)-1:0]  out_owner
);

    localparam int IW = iw_of(NREQ);

    state_t          state, state_nx;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   g;
    logic            any;
    logic            can_load;
    logic            grant;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .any   (any),
        .g     (g)
    );

    assign can_load = ~reset & ((state == ST_EMPTY) | out_ready);
    assign grant    = can_load & any;

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_EMPTY;
        else
            state <= state_nx;
    end

    // A grant while FULL refills in place, giving one word per cycle.
    always_comb begin
        state_nx = state;
        if (grant)
            state_nx = ST_FULL;
        else if (state == ST_FULL && out_ready)
            state_nx = ST_EMPTY;
    end

    always_comb begin
        req_ready = '0;
        reg_load  = 1'b0;
        reg_pi    = '0;
        out_valid = (state == ST_FULL);
        if (grant) begin
            req_ready[g] = 1'b1;
            reg_load     = 1'b1;
            reg_pi       = req_data[int'(g)*W +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            out_owner <= '0;
        end else if (grant) begin
            out_owner <= g;
            ptr       <= (g == IW'(NREQ - 1)) ? '0 : g + IW'(1);
        end
    end

endmodule

// File: tb/tb_pipo_rr_load_ctrl.sv
// Directed self-checking bench for pipo_rr_load_ctrl with a behavioural PIPO register.
module tb_pipo_rr_load_ctrl;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [NREQ-1:0] req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0] req_ready;
    logic            reg_load;
    logic [W-1:0]    reg_pi;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_owner;
    logic [W-1:0]    po;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] d [NREQ];
    int unsigned  exp_g [5];

    always #5 clk = ~clk;

    pipo_rr_load_ctrl #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .reg_load  (reg_load),
        .reg_pi    (reg_pi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_owner (out_owner)
    );

    // PIPO register shares the controller's reset
    always_ff @(posedge clk) begin
        if (reset)
            po <= '0;
        else if (reg_load)
            po <= reg_pi;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'hA5; d[3] = 8'h44;
        exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 2; exp_g[3] = 3; exp_g[4] = 0;
        req_data  = {d[3], d[2], d[1], d[0]};
        reset     = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;

        // Reset state, with requests present during reset
        tick();
        req_valid = 4'b1111;
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_load", 32'(reg_load), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_owner", 32'(out_owner), 32'h0);
        tick();
        chk("rst_po", 32'(po), 32'h0);

        // Single request on requester 2
        reset     = 1'b0;
        req_valid = 4'b0100;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h4);
        chk("t1_load", 32'(reg_load), 32'h1);
        chk("t1_pi", 32'(reg_pi), 32'hA5);
        tick();
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_owner", 32'(out_owner), 32'h2);
        chk("t1_po", 32'(po), 32'hA5);

        // FULL, downstream stalled: no grants, contents hold
        req_valid = 4'b1111;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_ready", 32'(req_ready), 32'h0);
            chk("t3_load", 32'(reg_load), 32'h0);
            tick();
            chk("t3_valid", 32'(out_valid), 32'h1);
            chk("t3_owner", 32'(out_owner), 32'h2);
            chk("t3_po", 32'(po), 32'hA5);
        end

        // Pop with no requests, then out_ready ignored while EMPTY
        req_valid = '0;
        out_ready = 1'b1;
        #1;
        chk("t5_ready", 32'(req_ready), 32'h0);
        tick();
        chk("t5_empty", 32'(out_valid), 32'h0);
        out_ready = 1'b0;
        req_valid = 4'b1000;
        #1;
        chk("t5_ready3", 32'(req_ready), 32'h8);
        chk("t5_pi", 32'(reg_pi), 32'h44);
        tick();
        chk("t5_valid", 32'(out_valid), 32'h1);
        chk("t5_owner", 32'(out_owner), 32'h3);
        chk("t5_po", 32'(po), 32'h44);

        // All valid, streaming at one word per cycle from ptr=0
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t2_ready", 32'(req_ready), 32'h1 << exp_g[i]);
            chk("t2_pi", 32'(reg_pi), 32'(d[exp_g[i]]));
            tick();
            chk("t2_valid", 32'(out_valid), 32'h1);
            chk("t2_owner", 32'(out_owner), exp_g[i]);
            chk("t2_po", 32'(po), 32'(d[exp_g[i]]));
        end

        // FULL, ptr=1, only requester 0 valid: wrap-around refill
        req_valid = 4'b0001;
        #1;
        chk("t4_ready", 32'(req_ready), 32'h1);
        tick();
        chk("t4_valid", 32'(out_valid), 32'h1);
        chk("t4_owner", 32'(out_owner), 32'h0);

        // Reset while FULL with requests pending (ptr=1 here)
        reset     = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("t6_ready", 32'(req_ready), 32'h0);
        chk("t6_load", 32'(reg_load), 32'h0);
        tick();
        chk("t6_valid", 32'(out_valid), 32'h0);
        chk("t6_po", 32'(po), 32'h0);
        chk("t6_owner", 32'(out_owner), 32'h0);
        reset     = 1'b0;
        req_valid = 4'b0101;
        out_ready = 1'b0;
        #1;
        chk("t6_ptr0", 32'(req_ready), 32'h1);
        tick();
        chk("t6_valid2", 32'(out_valid), 32'h1);
        chk("t6_po2", 32'(po), 32'h11);
        out_ready = 1'b1;
        #1;
        chk("t6_ptr1", 32'(req_ready), 32'h4);
        tick();
        chk("t6_owner2", 32'(out_owner), 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
